alu_exec_ctl: RTL and testbench

Parametrised ALU control and execute sequencer for the multicycle LEGv8 datapath. Decodes ALUOp/Opcode into the 4-bit ALU control code and executes the selected operation on WIDTH-bit operands. Single-cycle ops return after one cycle; MUL runs on an iterative shift-add engine. Sits between the decode stage (valid/ready in) and writeback (valid/ready out), and replaces the purely combinational ALU control.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_seq_mul.sv | 60 ++++++
 rtl/alu_exec_ctl.sv | 158 +++++++++++++++
 tb/tb_alu_exec_ctl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode patterns, ALU control codes and sequencer states for alu_exec_ctl.
// Optional MUL support is controlled by the ALU_MUL_EN macro in the users of this package.
package alu_pkg;

    // LEGv8 instruction[31:21] patterns; ORRI ignores the low opcode bit
    localparam logic [10:0] op_add  = 11'b10001011000;
    localparam logic [10:0] op_sub  = 11'b11001011000;
    localparam logic [10:0] op_and  = 11'b10001010000;
    localparam logic [10:0] op_orr  = 11'b10101010000;
    localparam logic [10:0] op_orri = 11'b1011001000?;
    localparam logic [10:0] op_lsl  = 11'b11010011011;
    localparam logic [10:0] op_lsr  = 11'b11010011010;
    localparam logic [10:0] op_mul  = 11'b10011011000;

    localparam logic [3:0] ctrl_and     = 4'b0000;
    localparam logic [3:0] ctrl_orr     = 4'b0001;
    localparam logic [3:0] ctrl_add     = 4'b0010;
    localparam logic [3:0] ctrl_lsl     = 4'b0011;
    localparam logic [3:0] ctrl_lsr     = 4'b0100;
    localparam logic [3:0] ctrl_mul     = 4'b0101;
    localparam logic [3:0] ctrl_sub     = 4'b0110;
    localparam logic [3:0] ctrl_passb   = 4'b0111;
    localparam logic [3:0] ctrl_illegal = 4'b1111;

    typedef enum logic [1:0] {
        st_idle,
        st_mul,
        st_done
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, finishing early once the
// remaining multiplier bits are all zero. Instantiated by alu_exec_ctl when ALU_MUL_EN is set.
module alu_seq_mul #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] last_step = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;
    logic [CW-1:0]    cnt;
    logic             busy;

    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] mplr_nxt;

    always_comb begin
        acc_nxt  = mplr[0] ? acc + mcand : acc;
        mplr_nxt = mplr >> 1;
    end

    // done and product reflect the step being taken this cycle
    assign done    = busy && ((mplr_nxt == '0) || (cnt == last_step));
    assign product = acc_nxt;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            acc   <= '0;
            mcand <= A;
            mplr  <= B;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            acc   <= acc_nxt;
            mcand <= mcand << 1;
            mplr  <= mplr_nxt;
            cnt   <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_ctl.sv
// ALU control decode plus execute sequencer between decode (valid/ready in) and writeback.
// Define ALU_MUL_EN to decode MUL and run it on the iterative alu_seq_mul engine.
module alu_exec_ctl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         ALUOp,
    input  logic [10:0]        Opcode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         ALUCtrl,
    output logic               zero,
    output logic               err
);

    state_t           state;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       ctrl_q;
    logic             err_q;
    logic             out_valid_q;
    logic             in_ready_q;

    logic [3:0]       dec_ctrl;
    logic [WIDTH-1:0] alu_res;
    logic             accept;
    logic             is_mul;

    always_comb begin
        dec_ctrl = ctrl_illegal;
        unique case (ALUOp)
            2'b00: dec_ctrl = ctrl_add;
            2'b01: dec_ctrl = ctrl_passb;
            2'b10: begin
                casez (Opcode)
                    op_add:          dec_ctrl = ctrl_add;
                    op_sub:          dec_ctrl = ctrl_sub;
                    op_and:          dec_ctrl = ctrl_and;
                    op_orr, op_orri: dec_ctrl = ctrl_orr;
                    op_lsl:          dec_ctrl = ctrl_lsl;
                    op_lsr:          dec_ctrl = ctrl_lsr;
`ifdef ALU_MUL_EN
                    op_mul:          dec_ctrl = ctrl_mul;
`endif
                    default:         dec_ctrl = ctrl_illegal;
                endcase
            end
            default: dec_ctrl = ctrl_illegal;
        endcase
    end

    // Illegal ops (and MUL, which is produced by the multiplier) yield zero here
    always_comb begin
        alu_res = '0;
        case (dec_ctrl)
            ctrl_add:   alu_res = A + B;
            ctrl_sub:   alu_res = A - B;
            ctrl_and:   alu_res = A & B;
            ctrl_orr:   alu_res = A | B;
            ctrl_lsl:   alu_res = A << shamt;
            ctrl_lsr:   alu_res = A >> shamt;
            ctrl_passb: alu_res = B;
            default:    alu_res = '0;
        endcase
    end

    // in_ready_q is only ever high in st_idle
    assign accept = in_valid && in_ready_q;

`ifdef ALU_MUL_EN
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign is_mul = (dec_ctrl == ctrl_mul);

    alu_seq_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .CLK    (CLK),
        .Reset_L(Reset_L),
        .start  (accept && is_mul),
        .A      (A),
        .B      (B),
        .done   (mul_done),
        .product(mul_product)
    );
`else
    assign is_mul = 1'b0;
`endif

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state       <= st_idle;
            result_q    <= '0;
            ctrl_q      <= 4'b0000;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                st_idle: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (is_mul) begin
                            state <= st_mul;
                        end else begin
                            result_q    <= alu_res;
                            ctrl_q      <= dec_ctrl;
                            err_q       <= (dec_ctrl == ctrl_illegal);
                            out_valid_q <= 1'b1;
                            state       <= st_done;
                        end
                    end
                end
`ifdef ALU_MUL_EN
                st_mul: begin
                    if (mul_done) begin
                        result_q    <= mul_product;
                        ctrl_q      <= ctrl_mul;
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= st_done;
                    end
                end
`endif
                st_done: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= st_idle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= st_idle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ALUCtrl   = ctrl_q;
    assign err       = err_q;
    assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_exec_ctl.sv
// Self-checking bench for alu_exec_ctl: directed vector table, MUL/backpressure/reset
// sequences, and randomized ops against a behavioural model. Honours ALU_MUL_EN.
module tb_alu_exec_ctl;

    localparam int W = 64;

    logic          CLK;
    logic          Reset_L;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    ALUOp;
    logic [10:0]   Opcode;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [5:0]    shamt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [3:0]    ALUCtrl;
    logic          zero;
    logic          err;

    int tests = 0;
    int fails = 0;

    alu_exec_ctl #(
        .WIDTH  (W),
        .SHAMT_W(6)
    ) dut (
        .CLK      (CLK),
        .Reset_L  (Reset_L),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ALUOp    (ALUOp),
        .Opcode   (Opcode),
        .A        (A),
        .B        (B),
        .shamt    (shamt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .ALUCtrl  (ALUCtrl),
        .zero     (zero),
        .err      (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]   op;
        logic [10:0]  opc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [5:0]   sh;
        logic [W-1:0] res;
        logic [3:0]   ctrl;
        logic         e;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model straight from the op table
    task automatic ref_model(input logic [1:0] op, input logic [10:0] opc,
                             input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] sh,
                             output logic [W-1:0] r, output logic [3:0] c, output logic e,
                             output int lat);
        int bl;
        r = '0; c = 4'b1111; e = 1'b1; lat = 1;
        if (op == 2'b00) begin
            r = a + b; c = 4'b0010; e = 1'b0;
        end else if (op == 2'b01) begin
            r = b; c = 4'b0111; e = 1'b0;
        end else if (op == 2'b10) begin
            e = 1'b0;
            if (opc == 11'b10001011000) begin r = a + b; c = 4'b0010; end
            else if (opc == 11'b11001011000) begin r = a - b; c = 4'b0110; end
            else if (opc == 11'b10001010000) begin r = a & b; c = 4'b0000; end
            else if (opc == 11'b10101010000 || opc[10:1] == 10'b1011001000) begin
                r = a | b; c = 4'b0001;
            end
            else if (opc == 11'b11010011011) begin r = a << sh; c = 4'b0011; end
            else if (opc == 11'b11010011010) begin r = a >> sh; c = 4'b0100; end
`ifdef ALU_MUL_EN
            else if (opc == 11'b10011011000) begin
                r = a * b; c = 4'b0101;
                bl = 0;
                for (int i = 0; i < W; i++) if (b[i]) bl = i + 1;
                lat = 1 + ((bl < 1) ? 1 : bl);
            end
`endif
            else begin r = '0; c = 4'b1111; e = 1'b1; end
        end
    endtask

    // Issue one op and wait (bounded) for its result; lat counts negedges after accept
    task automatic do_op(input logic [1:0] op, input logic [10:0] opc, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [5:0] sh, output int lat);
        @(negedge CLK);
        check("in_ready_before_issue", in_ready, 1);
        ALUOp = op; Opcode = opc; A = a; B = b; shamt = sh; in_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 80) begin
            @(negedge CLK);
            lat++;
        end
        check("in_ready_while_done", in_ready, 0);
    endtask

    task automatic release_out();
        @(negedge CLK);
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        int lat;
        int bad;
        logic [W-1:0] er;
        logic [3:0]   ec;
        logic         ee;
        int           el;
        logic [10:0]  opcs[10];

        Reset_L = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ALUOp = '0; Opcode = '0; A = '0; B = '0; shamt = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", result, 0);
        check("rst_ctrl", ALUCtrl, 0);
        check("rst_zero", zero, 1);
        check("rst_err", err, 0);
        @(negedge CLK);
        Reset_L = 1'b1;

        // Directed vector table
        vecs.push_back('{2'b10, 11'b10001011000, 64'd5, 64'd7, 6'd0, 64'd12, 4'b0010, 1'b0});
        vecs.push_back('{2'b10, 11'b11001011000, 64'h1234, 64'h1234, 6'd0, 64'd0, 4'b0110, 1'b0});
        vecs.push_back('{2'b10, 11'b11010011011, 64'd1, 64'd0, 6'd63,
                         64'h8000_0000_0000_0000, 4'b0011, 1'b0});
        vecs.push_back('{2'b10, 11'b10001010000, 64'hF0F0, 64'h0FF0, 6'd0, 64'h00F0, 4'b0000, 1'b0});
        vecs.push_back('{2'b10, 11'b10101010000, 64'hF000, 64'h000F, 6'd0, 64'hF00F, 4'b0001, 1'b0});
        vecs.push_back('{2'b10, 11'b10110010000, 64'd1, 64'd2, 6'd0, 64'd3, 4'b0001, 1'b0});
        vecs.push_back('{2'b10, 11'b10110010001, 64'd4, 64'd8, 6'd0, 64'hC, 4'b0001, 1'b0});
        vecs.push_back('{2'b10, 11'b11010011010, 64'h8000_0000_0000_0000, 64'd0, 6'd60,
                         64'd8, 4'b0100, 1'b0});
        vecs.push_back('{2'b01, 11'b00000000000, 64'd9, 64'hDEAD, 6'd0, 64'hDEAD, 4'b0111, 1'b0});
        vecs.push_back('{2'b00, 11'b11111111111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0,
                         64'd0, 4'b0010, 1'b0});
        vecs.push_back('{2'b11, 11'b10001011000, 64'd5, 64'd7, 6'd0, 64'd0, 4'b1111, 1'b1});
        vecs.push_back('{2'b10, 11'b11111111111, 64'd5, 64'd7, 6'd0, 64'd0, 4'b1111, 1'b1});
        vecs.push_back('{2'b10, 11'b11001011000, 64'd0, 64'd1, 6'd0,
                         64'hFFFF_FFFF_FFFF_FFFF, 4'b0110, 1'b0});
`ifndef ALU_MUL_EN
        vecs.push_back('{2'b10, 11'b10011011000, 64'd3, 64'd5, 6'd0, 64'd0, 4'b1111, 1'b1});
`endif
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].sh, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd1);
            check($sformatf("vec%0d_result", i), result, vecs[i].res);
            check($sformatf("vec%0d_ctrl", i), ALUCtrl, vecs[i].ctrl);
            check($sformatf("vec%0d_err", i), err, vecs[i].e);
            check($sformatf("vec%0d_zero", i), zero, 64'(vecs[i].res == '0));
            release_out();
        end

`ifdef ALU_MUL_EN
        // MUL 3*5: busy for three steps, result visible on the fourth cycle
        @(negedge CLK);
        ALUOp = 2'b10; Opcode = 11'b10011011000; A = 64'd3; B = 64'd5; in_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) @(negedge CLK);
            check($sformatf("mul35_in_ready_c%0d", i), in_ready, 0);
            check($sformatf("mul35_out_valid_c%0d", i), out_valid, 64'(i == 4));
        end
        check("mul35_result", result, 64'd15);
        check("mul35_ctrl", ALUCtrl, 4'b0101);
        check("mul35_err", err, 0);
        release_out();

        do_op(2'b10, 11'b10011011000, 64'd77, 64'd0, 6'd0, lat);
        check("mul_b0_latency", 64'(lat), 64'd2);
        check("mul_b0_result", result, 64'd0);
        check("mul_b0_zero", zero, 1);
        release_out();

        do_op(2'b10, 11'b10011011000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, lat);
        check("mul_ones_latency", 64'(lat), 64'd65);
        check("mul_ones_result", result, 64'd1);
        release_out();

        // Reset three steps into a MUL
        @(negedge CLK);
        ALUOp = 2'b10; Opcode = 11'b10011011000; A = 64'd7; B = 64'hFF; in_valid = 1'b1;
        @(posedge CLK);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #2 Reset_L = 1'b0;
        #1;
`else
        // Reset while a result is being held
        do_op(2'b10, 11'b10001011000, 64'd1, 64'd1, 6'd0, lat);
        #2 Reset_L = 1'b0;
        #1;
`endif
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge CLK);
        Reset_L = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge CLK);
            if (out_valid) bad++;
        end
        check("abort_no_result", 64'(bad), 0);
        do_op(2'b10, 11'b10001011000, 64'd2, 64'd2, 6'd0, lat);
        check("post_reset_add", result, 64'd4);
        release_out();

        // Backpressure: hold the ADD result three cycles, with a stray in_valid pulse
        do_op(2'b10, 11'b10001011000, 64'd5, 64'd7, 6'd0, lat);
        for (int i = 0; i < 3; i++) begin
            in_valid = (i == 1);
            ALUOp = 2'b10; Opcode = 11'b11001011000; A = 64'd100; B = 64'd1;
            @(negedge CLK);
            check($sformatf("bp_result_c%0d", i), result, 64'd12);
            check($sformatf("bp_ctrl_c%0d", i), ALUCtrl, 4'b0010);
            check($sformatf("bp_in_ready_c%0d", i), in_ready, 0);
            check($sformatf("bp_out_valid_c%0d", i), out_valid, 1);
        end
        in_valid = 1'b0;
        release_out();
        @(negedge CLK);
        check("bp_pulse_ignored", out_valid, 0);

        // Randomized ops against the model
        opcs = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                 11'b10110010000, 11'b10110010001, 11'b11010011011, 11'b11010011010,
                 11'b10011011000, 11'b00110101010};
        for (int n = 0; n < 40; n++) begin
            logic [1:0]   rop;
            logic [10:0]  ropc;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic [5:0]   rsh;
            rop  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) rop = 2'b10;
            ropc = opcs[$urandom_range(0, 9)];
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) rb = ra;
            rsh  = 6'($urandom_range(0, 63));
            ref_model(rop, ropc, ra, rb, rsh, er, ec, ee, el);
            do_op(rop, ropc, ra, rb, rsh, lat);
            check($sformatf("rnd%0d_latency", n), 64'(lat), 64'(el));
            check($sformatf("rnd%0d_result", n), result, er);
            check($sformatf("rnd%0d_ctrl", n), ALUCtrl, ec);
            check($sformatf("rnd%0d_err", n), err, ee);
            check($sformatf("rnd%0d_zero", n), zero, 64'(er == '0));
            release_out();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
